// File: rtl/rotation_cmd_parser.sv
// rotation_cmd_parser: turns ASCII rotation lines into direction/distance commands
module rotation_cmd_parser #(
  parameter int DIST_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              cmd_valid,
  output logic              cmd_direction,
  output logic [DIST_W-1:0] cmd_distance,
  input  logic              cmd_ready,
  output logic [CNT_W-1:0]  cmd_count,
  output logic [CNT_W-1:0]  err_count
);
  localparam logic [1:0] IDLE = 2'd0, DIGITS = 2'd1, SEND = 2'd2, SKIP = 2'd3;
  logic [1:0]        state;
  logic              has_digit;
  logic              take, is_nl, is_dig, is_dir;
  logic [DIST_W+3:0] wide;
  logic [DIST_W-1:0] next_acc;
  assign in_ready  = state != SEND;
  assign cmd_valid = state == SEND;
  assign take      = in_valid && in_ready && in_data != 8'h0D;
  assign is_nl     = in_data == 8'h0A;
  assign is_dig    = in_data >= "0" && in_data <= "9";
  assign is_dir    = in_data == "R" || in_data == "L";
  assign wide      = {4'b0, cmd_distance} * (DIST_W+4)'(10) + (DIST_W+4)'(in_data[3:0]);
  assign next_acc  = wide > {4'b0, {DIST_W{1'b1}}} ? {DIST_W{1'b1}} : wide[DIST_W-1:0];
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      has_digit     <= 1'b0;
      cmd_direction <= 1'b0;
      cmd_distance  <= '0;
      cmd_count     <= '0;
    end else begin
      case (state)
        IDLE: if (take) begin
          if (is_dir) begin
            cmd_direction <= in_data == "R";
            cmd_distance  <= '0;
            has_digit     <= 1'b0;
            state         <= DIGITS;
          end else if (!is_nl) state <= SKIP;
        end
        DIGITS: if (take) begin
          if (is_dig) begin
            cmd_distance <= next_acc;
            has_digit    <= 1'b1;
          end else if (is_nl) state <= has_digit ? SEND : IDLE;
          else state <= SKIP;
        end
        SEND: if (cmd_ready) begin
          cmd_count <= cmd_count + CNT_W'(1);
          state     <= IDLE;
        end
        SKIP: if (take && is_nl) state <= IDLE;
      endcase
    end
  end
`ifdef PARSER_ERR_COUNT_EN
  logic err_inc;
  assign err_inc = take && ((state == IDLE && !is_dir && !is_nl) ||
                            (state == DIGITS && !is_dig && !(is_nl && has_digit)));
  always_ff @(posedge clk) begin
    if (rst) err_count <= '0;
    else if (err_inc) err_count <= err_count + CNT_W'(1);
  end
`else
  assign err_count = '0;
`endif
endmodule

// File: tb/tb_rotation_cmd_parser.sv
// tb_rotation_cmd_parser: directed and random streams checked against a line-level reference model.
module tb_rotation_cmd_parser;
   localparam int DIST_W = 16;
   localparam int CNT_W  = 16;
   localparam longint MAXV = (64'd1 << DIST_W) - 1;
   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              in_valid = 1'b0;
   logic [7:0]        in_data = 8'h00;
   logic              in_ready;
   logic              cmd_valid;
   logic              cmd_direction;
   logic [DIST_W-1:0] cmd_distance;
   logic              cmd_ready = 1'b0;
   logic [CNT_W-1:0]  cmd_count;
   logic [CNT_W-1:0]  err_count;
   int checks = 0, failures = 0;
   logic [DIST_W:0] exp_q[$];
   byte line_q[$];
   int exp_cmd = 0, exp_err = 0;
   bit stall_en = 0, done = 0;

   rotation_cmd_parser #(.DIST_W(DIST_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
      .cmd_valid(cmd_valid), .cmd_direction(cmd_direction), .cmd_distance(cmd_distance),
      .cmd_ready(cmd_ready), .cmd_count(cmd_count), .err_count(err_count));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   function automatic int err_expected();
`ifdef PARSER_ERR_COUNT_EN
      return exp_err;
`else
      return 0;
`endif
   endfunction

   // whole-line interpretation: strip CRs, then accept only [RL][0-9]+
   task automatic model_line();
      byte t[$];
      bit ok;
      longint v = 0;
      foreach (line_q[i]) if (line_q[i] != 8'h0D) t.push_back(line_q[i]);
      line_q.delete();
      if (t.size() == 0) return;
      ok = (t[0] == "R" || t[0] == "L") && t.size() > 1;
      for (int i = 1; i < t.size(); i++) if (t[i] < "0" || t[i] > "9") ok = 0;
      if (!ok) begin
         exp_err++;
         return;
      end
      for (int i = 1; i < t.size(); i++) begin
         v = v * 10 + longint'(t[i] - "0");
         if (v > MAXV) v = MAXV;
      end
      exp_q.push_back({t[0] == "R", DIST_W'(v)});
      exp_cmd++;
   endtask

   task automatic send_byte(input byte b);
      int n = 0;
      if (stall_en) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      if (b == 8'h0A) model_line();
      else line_q.push_back(b);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 1000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 1000) check("in_ready_timeout", 0, 1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send_byte(s[i]);
   endtask

   task automatic drain();
      int n = 0;
      while ((exp_q.size() != 0 || cmd_valid) && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 2000) check("drain_timeout", 0, 1);
   endtask

   // a command transfers at the next edge when both valid and ready are high here
   always @(negedge clk) begin
      if (!rst && cmd_valid && cmd_ready) begin
         if (exp_q.size() == 0) check("unexpected_cmd", 1, 0);
         else begin
            logic [DIST_W:0] e;
            e = exp_q.pop_front();
            check("cmd_direction", cmd_direction, e[DIST_W]);
            check("cmd_distance", cmd_distance, e[DIST_W-1:0]);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_cmd_valid", cmd_valid, 0);
      check("rst_direction", cmd_direction, 0);
      check("rst_distance", cmd_distance, 0);
      check("rst_cmd_count", cmd_count, 0);
      check("rst_err_count", err_count, 0);

      cmd_ready = 1'b1;
      send_str("R42\n");
      check("latency_cmd_valid", cmd_valid, 1);
      send_str("L7\n");
      drain();
      check("basic_cmd_count", cmd_count, CNT_W'(exp_cmd));
      check("basic_err_count", err_count, 0);

      cmd_ready = 1'b0;
      send_str("R5\n");
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("hold_valid", cmd_valid, 1);
         check("hold_in_ready", in_ready, 0);
         check("hold_dir", cmd_direction, 1);
         check("hold_dist", cmd_distance, 5);
      end
      @(posedge clk);
      #1 cmd_ready = 1'b1;
      @(posedge clk);
      #1;
      check("hold_released", cmd_valid, 0);
      check("hold_cmd_count", cmd_count, 3);

      send_str("X12\nR\nL3a\n\nL003\r\n");
      drain();
      check("bad_cmd_count", cmd_count, 4);
      check("bad_err_count", err_count, CNT_W'(err_expected()));

      send_str("R70000\n");
      drain();
      check("sat_cmd_count", cmd_count, 5);

      send_str("L12");
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      line_q.delete();
      exp_cmd = 0;
      exp_err = 0;
      check("mid_rst_cmd_count", cmd_count, 0);
      check("mid_rst_err_count", err_count, 0);
      check("mid_rst_valid", cmd_valid, 0);
      send_str("R1\n");
      drain();
      check("after_rst_cmd_count", cmd_count, 1);

      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_cmd = 0;
      exp_err = 0;
      stall_en = 1;
      fork
         begin
            for (int l = 0; l < 1000; l++) begin
               send_byte($urandom_range(0, 1) ? "R" : "L");
               repeat ($urandom_range(1, 6)) send_byte(byte'("0" + $urandom_range(0, 9)));
               if ($urandom_range(0, 9) == 0) send_byte(8'h0D);
               send_byte(8'h0A);
            end
            drain();
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 cmd_ready = $urandom_range(0, 2) != 0;
            end
         end
      join
      cmd_ready = 1'b1;
      check("rand_cmd_count", cmd_count, 1000);
      check("rand_model_count", cmd_count, CNT_W'(exp_cmd));
      check("rand_err_count", err_count, 0);
      check("rand_queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
